// File: rtl/pixel_write_pkg.sv
// Shared types and constants for the UART-to-framebuffer pixel writer.
// Frame wrap behaviour is selected in the top level by PIXEL_WC_FRAME_WRAP_EN.
package pixel_write_pkg;

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_WRITE = 3'd1,
    S_INC   = 3'd2,
    S_DONE  = 3'd3
  } pw_state_t;

  localparam int BYTES_PER_PIXEL    = 3;
  localparam int PIXEL_W            = 8 * BYTES_PER_PIXEL;
  localparam int DEFAULT_IMG_PIXELS = 66564;
  localparam int DEFAULT_ADDR_W     = 18;

  // True when the byte being packed completes the current pixel.
  function automatic logic is_last_byte(input logic [1:0] cnt);
    return cnt == 2'(BYTES_PER_PIXEL - 1);
  endfunction

endpackage

// File: rtl/pixel_write_controller_rx_edge_detect.sv
// Rising-edge detector for the UART RX byte-valid strobe; a strobe held
// for several cycles yields a single-cycle rise pulse.
module rx_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_d;

  always_ff @(posedge clk) begin
    if (!rst) in_d <= 1'b0;
    else      in_d <= in;
  end

  assign rise = in & ~in_d;

endmodule

// File: rtl/pixel_write_controller.sv
// Packs UART bytes into 24-bit RGB pixels and writes them sequentially to BRAM.
// Define PIXEL_WC_FRAME_WRAP_EN to restart at address 0 after the last pixel.
module pixel_write_controller
  import pixel_write_pkg::*;
#(
  parameter int IMG_PIXELS = DEFAULT_IMG_PIXELS,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          byte_received,
  input  logic                rx_data_ready,
  output logic                en,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [PIXEL_W-1:0]  din,
  output logic [2:0]          status,
  output logic [2:0]          status_next,
  output logic [PIXEL_W-1:0]  array,
  output logic [1:0]          byte_counter
);

  // Handshake: byte_received is valid while rx_data_ready is high; each rising
  // edge of rx_data_ready is one byte. There is no back-pressure: a byte that
  // arrives while a pixel is being written is held in a 1-deep pending slot.
  // IMG_PIXELS must not exceed 2**ADDR_W.

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  pw_state_t             state_q, state_d;
  logic                  rise;
  logic                  pending_q;
  logic                  take_byte;
  logic                  at_last;
  logic [ADDR_W-1:0]     addr_q;
  logic [PIXEL_W-1:0]    array_q, array_d;
  logic [PIXEL_W-1:0]    din_q;
  logic [1:0]            cnt_q;

  rx_edge_detect u_rx_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (rx_data_ready),
    .rise (rise)
  );

  assign at_last = (addr_q == LAST_ADDR);
  assign array_d = {array_q[PIXEL_W-9:0], byte_received};

  always_comb begin
    state_d   = state_q;
    take_byte = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (rise || pending_q) begin
          take_byte = 1'b1;
          if (is_last_byte(cnt_q)) state_d = S_WRITE;
        end
      end
      S_WRITE: state_d = S_INC;
      S_INC: begin
`ifdef PIXEL_WC_FRAME_WRAP_EN
        state_d = S_WAIT;
`else
        state_d = at_last ? S_DONE : S_WAIT;
`endif
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_WAIT;
      addr_q    <= '0;
      array_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      din_q     <= '0;
    end else begin
      state_q <= state_d;

      if (take_byte) begin
        array_q <= array_d;
        cnt_q   <= is_last_byte(cnt_q) ? 2'd0 : cnt_q + 2'd1;
      end

      // A rise during the write/increment cycles is remembered for the next S_WAIT.
      if (state_q == S_WAIT)
        pending_q <= 1'b0;
      else if ((state_q == S_WRITE || state_q == S_INC) && rise)
        pending_q <= 1'b1;
      else if (state_q != S_WRITE && state_q != S_INC)
        pending_q <= 1'b0;

      if (state_q == S_WAIT && state_d == S_WRITE)
        din_q <= array_d;

      if (state_q == S_INC) begin
        if (!at_last)
          addr_q <= addr_q + ADDR_W'(1);
`ifdef PIXEL_WC_FRAME_WRAP_EN
        else
          addr_q <= '0;
`endif
      end
    end
  end

  assign en           = (state_q == S_WRITE);
  assign we           = (state_q == S_WRITE);
  assign addr         = addr_q;
  assign din          = din_q;
  assign status       = state_q;
  assign status_next  = state_d;
  assign array        = array_q;
  assign byte_counter = cnt_q;

endmodule

// File: tb/tb_pixel_write_controller.sv
// Directed bench for pixel_write_controller with a small frame (8 pixels);
// BRAM writes are scored against an expected {addr,din} queue.
module tb_pixel_write_controller;

  localparam int ADDR_W = 18;
  localparam int NPIX   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        byte_received = 8'h00;
  logic              rx_data_ready = 1'b0;
  logic              en, we;
  logic [ADDR_W-1:0] addr;
  logic [23:0]       din;
  logic [2:0]        status, status_next;
  logic [23:0]       array;
  logic [1:0]        byte_counter;

  logic [ADDR_W+23:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int n_writes = 0;
  int n_exp    = 0;

  pixel_write_controller #(.IMG_PIXELS(NPIX), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .byte_received (byte_received),
    .rx_data_ready (rx_data_ready),
    .en            (en),
    .we            (we),
    .addr          (addr),
    .din           (din),
    .status        (status),
    .status_next   (status_next),
    .array         (array),
    .byte_counter  (byte_counter)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    byte_received = b;
    rx_data_ready = 1'b1;
    repeat (hold) @(negedge clk);
    rx_data_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    exp_q.push_back({a, d});
    n_exp++;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // scoreboard: every BRAM write must match the head of the expected queue
  always @(negedge clk) begin
    if (en || we) begin
      logic [ADDR_W+23:0] e;
      n_writes++;
      check("en_eq_we", 64'(en), 64'(we));
      if (exp_q.size() == 0) begin
        check("spurious_write", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_din", 64'({addr, din}), 64'(e));
      end
    end
  end

  initial begin
    // 1: reset held with a toggling strobe
    for (int i = 0; i < 5; i++) begin
      rx_data_ready = ~rx_data_ready;
      byte_received = 8'(i + 8'h40);
      @(negedge clk);
    end
    check("rst_status", 64'(status), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_array", 64'(array), 64'd0);
    check("rst_cnt", 64'(byte_counter), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_din", 64'(din), 64'd0);
    rx_data_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 2: first pixel, with cycle-exact latency
    send_byte(8'h01, 1, 5);
    send_byte(8'h02, 1, 5);
    check("t2_cnt", 64'(byte_counter), 64'd2);
    check("t2_array", 64'(array), 64'h000102);
    push_exp(0, 24'h010203);
    byte_received = 8'h03;
    rx_data_ready = 1'b1;
    @(negedge clk);
    check("t2_en", 64'(en), 64'd1);
    check("t2_we", 64'(we), 64'd1);
    check("t2_din", 64'(din), 64'h010203);
    check("t2_addr_w", 64'(addr), 64'd0);
    check("t2_status_w", 64'(status), 64'd1);
    check("t2_next_w", 64'(status_next), 64'd2);
    rx_data_ready = 1'b0;
    @(negedge clk);
    check("t2_en_off", 64'(en), 64'd0);
    check("t2_status_inc", 64'(status), 64'd2);
    check("t2_addr_inc", 64'(addr), 64'd0);
    @(negedge clk);
    check("t2_status_wait", 64'(status), 64'd0);
    check("t2_addr_1", 64'(addr), 64'd1);
    check("t2_cnt_0", 64'(byte_counter), 64'd0);
    repeat (3) @(negedge clk);

    // 3: long strobe counts once
    send_byte(8'hAA, 5, 2);
    check("t3_cnt", 64'(byte_counter), 64'd1);
    check("t3_array_lo", 64'(array[7:0]), 64'hAA);
    push_exp(1, 24'hAABBCC);
    send_byte(8'hBB, 1, 5);
    send_byte(8'hCC, 1, 5);
    check("t3_addr", 64'(addr), 64'd2);

    // 5: mid-pixel reset discards partial data
    send_byte(8'h55, 1, 3);
    send_byte(8'h66, 1, 3);
    check("t5_cnt_pre", 64'(byte_counter), 64'd2);
    pulse_reset();
    check("t5_addr", 64'(addr), 64'd0);
    check("t5_cnt", 64'(byte_counter), 64'd0);
    check("t5_array", 64'(array), 64'd0);
    check("t5_status", 64'(status), 64'd0);
    push_exp(0, 24'h102030);
    send_byte(8'h10, 1, 5);
    send_byte(8'h20, 1, 5);
    send_byte(8'h30, 1, 5);
    check("t5_addr_after", 64'(addr), 64'd1);

    // 6: strobe landing in S_INC is held pending and packed afterwards
    push_exp(1, 24'h112233);
    push_exp(2, 24'h445566);
    send_byte(8'h11, 1, 3);
    send_byte(8'h22, 1, 3);
    byte_received = 8'h33;
    rx_data_ready = 1'b1;
    @(negedge clk);
    check("t6_status_w", 64'(status), 64'd1);
    rx_data_ready = 1'b0;
    @(negedge clk);
    check("t6_status_inc", 64'(status), 64'd2);
    byte_received = 8'h44;
    rx_data_ready = 1'b1;
    @(negedge clk);
    check("t6_status_wait", 64'(status), 64'd0);
    check("t6_addr", 64'(addr), 64'd2);
    check("t6_cnt_pending", 64'(byte_counter), 64'd0);
    rx_data_ready = 1'b0;
    @(negedge clk);
    check("t6_cnt_packed", 64'(byte_counter), 64'd1);
    check("t6_array_lo", 64'(array[7:0]), 64'h44);
    send_byte(8'h55, 1, 5);
    send_byte(8'h66, 1, 5);
    check("t6_addr_after", 64'(addr), 64'd3);

    // 4: full frame of NPIX pixels, bytes 1,2,3,...
    pulse_reset();
    for (int p = 0; p < NPIX; p++) begin
      push_exp(ADDR_W'(p), {8'(3*p+1), 8'(3*p+2), 8'(3*p+3)});
      for (int k = 1; k <= 3; k++) send_byte(8'(3*p+k), 1, 3);
    end
    repeat (2) @(negedge clk);
    check("t4_last_din", 64'(din), 64'h161718);
    check("t4_writes", 64'(n_writes), 64'(n_exp));
`ifdef PIXEL_WC_FRAME_WRAP_EN
    check("t4_status_wrap", 64'(status), 64'd0);
    check("t4_addr_wrap", 64'(addr), 64'd0);
    push_exp(0, 24'h999999);
    for (int k = 0; k < 3; k++) send_byte(8'h99, 1, 3);
    check("t4_addr_next", 64'(addr), 64'd1);
`else
    check("t4_status_done", 64'(status), 64'd3);
    check("t4_addr_hold", 64'(addr), 64'(NPIX - 1));
    for (int k = 0; k < 3; k++) send_byte(8'h99, 1, 3);
    check("t4_status_stay", 64'(status), 64'd3);
    check("t4_addr_stay", 64'(addr), 64'(NPIX - 1));
`endif

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("total_writes", 64'(n_writes), 64'(n_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
